main_mem_arbiter: RTL
=====================

# main_mem_arbiter

- Shares the single main-memory port between two cache controllers (requester 0 = I-side, requester 1 = D-side).
- Each requester uses the same main-memory handshake as `cache_controller`: a level read/write request, a 32-bit address, 32-bit write data, a 512-bit line return and a one-cycle ready.
- Arbitration is round-robin. One transaction is in flight at a time.
- Sits between the controllers and the main-memory model/interface.

## Interface
Parameters:
- ADDR_W, 32, address width
- WDATA_W, 32, write-data width (one word per write)
- LINE_W, 512, read-line width
- TIMEOUT, 255, maximum number of WAIT cycles before an abort

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- rqN_addr (N=0,1)  in  ADDR_W  request address
- rqN_wdata  in  WDATA_W  write data
- rqN_read_req  in  1  level read request, held until rqN_ready
- rqN_write_req  in  1  level write request, held until rqN_ready
- rqN_rdata  out  LINE_W  registered line data of the last read completed for N
- rqN_ready  out  1  one-cycle completion pulse
- rqN_err  out  1  one-cycle pulse, coincident with rqN_ready, when the transaction timed out
- mem_addr  out  ADDR_W  address to memory
- mem_data_out  out  WDATA_W  write data to memory
- mem_read_req  out  1  one-cycle read launch pulse
- mem_write_req  out  1  one-cycle write launch pulse
- mem_data_in  in  LINE_W  line from memory, valid while mem_ready=1
- mem_ready  in  1  memory completion
- grant_id  out  1  requester currently owning the port
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - Pending for requester N = rqN_read_req | rqN_write_req.
  - If exactly one requester is pending, it wins.
  - If both are pending, the requester that did not win last (last_grant pointer) wins. Update last_grant.
  - Latch the winner's address, write data and op. Write wins if read and write are asserted together (write-back before refill).
  - Go to ISSUE.
- **ISSUE:** assert mem_read_req or mem_write_req for exactly one cycle. Clear the timeout counter. Go to WAIT.
- **WAIT:**
  - mem_*_req stays 0.
  - Count cycles. When mem_ready=1: if the op was a read, capture mem_data_in into the winner's rqN_rdata register. Go to RESP.
  - If the count reaches TIMEOUT with no mem_ready, set the internal err flag and go to RESP. rdata is unchanged.
- **RESP:**
  - rqN_ready=1 for the winner only. rqN_err=1 if the flag is set.
  - Request inputs are ignored this cycle, so a stale level request is never re-serviced.
  - Go to IDLE.
- mem_addr and mem_data_out hold the latched values from ISSUE through RESP, and are 0 in IDLE.
- mem_ready outside WAIT is ignored.
- rqN_rdata is updated only by a completed read for N. It holds otherwise, including across writes and timeouts.

## Timing
- Reset values:
  - All outputs 0, including rqN_rdata.
  - FSM in IDLE.
  - last_grant=1, so requester 0 is preferred first.
- Request sampled high at edge t (IDLE): mem_*_req is high during cycle t+1 (ISSUE).
- Memory asserts mem_ready in cycle k: rqN_ready is high in cycle k+1 (RESP), and IDLE resumes at k+2.
- Arbiter overhead: 3 cycles plus memory latency.
- Back-to-back use: the requester drops its request on the edge after seeing ready. The other requester's pending request wins at the next IDLE edge.
- Reset mid-transaction: immediate return to IDLE with all outputs 0. An outstanding memory op is abandoned and its later mem_ready is ignored.
- grant_id is valid from ISSUE through RESP and holds its last value in IDLE.

## Configuration
- Macro: MEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. Requester 1 (D-side) always wins when both are pending, and last_grant is unused. Requester 0 can starve.
- Undefined (default): round-robin as described in Operation.

## Test plan
- Single read: rq0_read_req=1, addr 0x0000_1040; memory ready 4 cycles after launch with line 0xA5…A5 → one mem_read_req pulse with mem_addr=0x0000_1040, then rq0_ready pulse with rq0_rdata=0xA5…A5, rq1_ready=0.
- Simultaneous requests from reset: rq0 read 0x100 and rq1 write 0x200 (data 0xDEADBEEF) asserted together → rq0 served first, then rq1 with mem_data_out=0xDEADBEEF. A third pair asserted together → rq1 first.
- Read and write both asserted by rq1: rq1_read_req=rq1_write_req=1, addr 0x340 → mem_write_req pulses, mem_read_req stays 0.
- Timeout: rq0 read, memory never responds → rq0_ready and rq0_err pulse together 256 cycles after ISSUE, rq0_rdata unchanged, then IDLE.
- Reset mid-op: assert rst_n=0 during WAIT, then inject mem_ready after release → all outputs 0, no rqN_ready pulse.
- With MEM_ARB_FIXED_PRIO_EN defined: both requesters assert continuously for three transactions → rq1 granted all three.

Source files
------------

// File: rtl/main_mem_arbiter.sv
// main_mem_arbiter
// Shares the single main-memory port between two cache controllers
// (requester 0 = I-side, requester 1 = D-side). One transaction is in flight
// at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// Contention is resolved round-robin on a last_grant pointer that only moves
// when both requesters were pending. Build macro MEM_ARB_FIXED_PRIO_EN switches
// to fixed priority where requester 1 always wins contention.
module main_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int WDATA_W = 32,
  parameter int LINE_W  = 512,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  // requester 0 (I-side)
  input  logic [ADDR_W-1:0]  rq0_addr,
  input  logic [WDATA_W-1:0] rq0_wdata,
  input  logic               rq0_read_req,
  input  logic               rq0_write_req,
  output logic [LINE_W-1:0]  rq0_rdata,
  output logic               rq0_ready,
  output logic               rq0_err,
  // requester 1 (D-side)
  input  logic [ADDR_W-1:0]  rq1_addr,
  input  logic [WDATA_W-1:0] rq1_wdata,
  input  logic               rq1_read_req,
  input  logic               rq1_write_req,
  output logic [LINE_W-1:0]  rq1_rdata,
  output logic               rq1_ready,
  output logic               rq1_err,
  // main-memory port
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [WDATA_W-1:0] mem_data_out,
  output logic               mem_read_req,
  output logic               mem_write_req,
  input  logic [LINE_W-1:0]  mem_data_in,
  input  logic               mem_ready,
  // status
  output logic               grant_id,
  output logic               busy
);

  // The wait counter runs 0 .. TIMEOUT-1; reaching TIMEOUT-1 without
  // mem_ready ends the WAIT phase after exactly TIMEOUT cycles.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t             state_q;
  state_t             state_d;

  logic               pend0;
  logic               pend1;
  logic               win_id;
  logic               win_write;
  logic [ADDR_W-1:0]  win_addr;
  logic [WDATA_W-1:0] win_wdata;

  logic               grant_q;
  logic               op_write_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [WDATA_W-1:0] wdata_q;
  logic               err_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [LINE_W-1:0]  rdata0_q;
  logic [LINE_W-1:0]  rdata1_q;

  logic               wait_done;
  logic               timeout_hit;

  assign pend0 = rq0_read_req | rq0_write_req;
  assign pend1 = rq1_read_req | rq1_write_req;

`ifdef MEM_ARB_FIXED_PRIO_EN
  // Fixed priority: the D-side wins whenever it is pending.
  assign win_id = pend1;
`else
  logic contend;
  logic last_grant_q;

  assign contend = pend0 & pend1;
  // Round-robin: under contention the requester that did not win last time wins.
  assign win_id  = contend ? ~last_grant_q : pend1;

  // last_grant only moves on contention, so a lone requester does not
  // steal the next turn from the other side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else if (state_q == IDLE && contend) begin
      last_grant_q <= win_id;
    end
  end
`endif

  // Winner's transaction fields; write wins over read so a write-back
  // goes out ahead of the refill that triggered it.
  assign win_write = win_id ? rq1_write_req : rq0_write_req;
  assign win_addr  = win_id ? rq1_addr      : rq0_addr;
  assign win_wdata = win_id ? rq1_wdata     : rq0_wdata;

  assign timeout_hit = (state_q == WAIT) && !mem_ready && (cnt_q == CNT_LAST);
  assign wait_done   = (state_q == WAIT) && (mem_ready || (cnt_q == CNT_LAST));

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; RESP always returns to IDLE so a held request is
  // not re-sampled in the same cycle its ready pulse is visible.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pend0 || pend1) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (wait_done) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch the winning transaction at the IDLE decision point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q    <= 1'b0;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else if (state_q == IDLE && (pend0 || pend1)) begin
      grant_q    <= win_id;
      op_write_q <= win_write;
      addr_q     <= win_addr;
      wdata_q    <= win_wdata;
    end
  end

  // Wait-cycle counter and timeout flag; both restart at ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (state_q == ISSUE) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (state_q == WAIT && !mem_ready) begin
      if (timeout_hit) begin
        err_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Line capture: only a completed read updates the owner's rdata register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if (state_q == WAIT && mem_ready && !op_write_q) begin
      if (grant_q) begin
        rdata1_q <= mem_data_in;
      end else begin
        rdata0_q <= mem_data_in;
      end
    end
  end

  // Output decode from the registered state.
  always_comb begin
    mem_read_req  = 1'b0;
    mem_write_req = 1'b0;
    rq0_ready     = 1'b0;
    rq1_ready     = 1'b0;
    busy          = (state_q != IDLE);
    mem_addr      = busy ? addr_q  : '0;
    mem_data_out  = busy ? wdata_q : '0;
    if (state_q == ISSUE) begin
      mem_read_req  = ~op_write_q;
      mem_write_req = op_write_q;
    end
    if (state_q == RESP) begin
      rq0_ready = ~grant_q;
      rq1_ready = grant_q;
    end
  end

  assign rq0_err   = rq0_ready & err_q;
  assign rq1_err   = rq1_ready & err_q;
  assign rq0_rdata = rdata0_q;
  assign rq1_rdata = rdata1_q;
  assign grant_id  = grant_q;

endmodule
